// File: rtl/uart_rx_pkg.sv
// Shared definitions for the multi-format UART receiver: FSM states,
// error-flag bit positions inside a FIFO entry, and the divisor floor.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        WAIT_HI = 3'd5,
        STORE   = 3'd6
    } rx_state_e;

    // Bit positions of the flags within the 2-bit error field.
    localparam int ERR_FRAMING = 0;
    localparam int ERR_PARITY  = 1;

    // Smallest usable divisor; smaller requests are clamped to this.
    localparam int MIN_BAUDRATE = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// Single-clock show-ahead FIFO. Storage is a plain array with a registered
// read port; the read address is steered to the next head so the output
// register already holds the head entry. A one-entry bypass covers the case
// where the entry being written is the one that becomes the head.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] ram_q;
    logic [WIDTH-1:0] byp_data_q;
    logic             byp_valid_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wr_en, rd_en;
    logic [AW-1:0]    rd_addr;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // Reads only when data exists; writes when space exists or a pop frees a slot.
    assign rd_en   = rd && !empty;
    assign wr_en   = wr && (!full || rd_en);
    assign rd_addr = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array with registered read of the upcoming head.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= din;
        ram_q <= mem[rd_addr];
    end

    // Pointers, occupancy and the write-to-head bypass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            byp_valid_q <= 1'b0;
            byp_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            byp_valid_q <= wr_en && (wr_ptr_q == rd_addr);
            byp_data_q  <= din;
        end
    end

    // Output is forced to zero while empty so nothing stale is presented.
    assign dout = empty ? '0 : (byp_valid_q ? byp_data_q : ram_q);

endmodule

// File: rtl/uart_rx_multi.sv
// Oversampling UART receiver with 5..9 data bits, 1 or 2 stop bits,
// false-start rejection and an internal show-ahead FIFO of {flags, word}.
// Optional parity checking is built when UART_RX_PARITY_EN is defined,
// which also adds the parity_odd input.
module uart_rx_multi
    import uart_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int STOP_BITS  = 1,
    parameter int DIV_W      = 13,
    parameter int FIFO_DEPTH = 2048
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DIV_W-1:0]              BaudRate,
    input  logic                          RXD,
`ifdef UART_RX_PARITY_EN
    input  logic                          parity_odd,
`endif
    input  logic                          fifo_rdreq,
    output logic [DATA_W-1:0]             fifo_data,
    output logic [1:0]                    fifo_err,
    output logic                          RXD_DATA_VALID_STATUS,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic                          rx_busy
);

    logic             sync1_q, sync2_q;
    logic             line, fall;
    rx_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic             par_err_q, par_err_d;
    logic             frm_err_q, frm_err_d;
    logic             held_q, held_d;
    logic [DIV_W-1:0] limit_m1;
    logic             tick;
    logic             fifo_wr;
    logic [DATA_W+1:0] fifo_din, fifo_dout;
    logic             fifo_full, fifo_empty;

    // Two-flop synchroniser; both flops idle high so reset is not seen as a start edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= RXD;
            sync2_q <= sync1_q;
        end
    end

    assign line = sync1_q;
    assign fall = sync2_q && !sync1_q;

    // Sample point: half a bit in START, a full bit elsewhere, using the latched divisor.
    assign limit_m1 = (state_q == START) ? (baud_q >> 1) - DIV_W'(1) : baud_q - DIV_W'(1);
    assign tick     = (cnt_q == limit_m1);

    // Frame FSM: next state, bit-period counter, shift register and error flags.
    always_comb begin
        state_d   = state_q;
        cnt_d     = tick ? '0 : cnt_q + DIV_W'(1);
        baud_d    = baud_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        held_d    = held_q;
        fifo_wr   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d   = START;
                    baud_d    = (BaudRate < DIV_W'(MIN_BAUDRATE)) ? DIV_W'(MIN_BAUDRATE) : BaudRate;
                    bit_cnt_d = '0;
                    par_err_d = 1'b0;
                    frm_err_d = 1'b0;
                end
            end
            START: begin
                if (tick) state_d = line ? IDLE : DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_d   = {line, shift_q[DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    par_err_d = line ^ (^shift_q) ^ parity_odd;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (!line) frm_err_d = 1'b1;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                        bit_cnt_d = '0;
                        held_d    = 1'b0;
                        state_d   = (frm_err_q || !line) ? WAIT_HI : STORE;
                    end
                end
            end
            WAIT_HI: begin
                // Store once on entry, then sit out the break until the line is high.
                cnt_d   = '0;
                fifo_wr = !held_q;
                held_d  = 1'b1;
                if (line) state_d = IDLE;
            end
            STORE: begin
                cnt_d   = '0;
                fifo_wr = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            baud_q    <= DIV_W'(MIN_BAUDRATE);
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            baud_q    <= baud_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            held_q    <= held_d;
        end
    end

    assign fifo_din = {par_err_q, frm_err_q, shift_q};

    uart_rx_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clock),
        .rst   (reset),
        .wr    (fifo_wr),
        .rd    (fifo_rdreq),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign fifo_data             = fifo_dout[DATA_W-1:0];
    assign fifo_err              = fifo_dout[DATA_W+1:DATA_W];
    assign RXD_DATA_VALID_STATUS = !fifo_empty;
    assign overrun               = fifo_wr && fifo_full && !fifo_rdreq;
    assign rx_busy               = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_multi.sv
// Self-checking bench for uart_rx_multi (8 data bits, 1 stop bit, 4-entry FIFO).
// Expected FIFO entries come from a frame-level model: word as sent, framing
// flag = stop bit low, parity flag = received parity disagrees with the mode.
module tb_uart_rx_multi;

    localparam int DW    = 8;
    localparam int SB    = 1;
    localparam int DIVW  = 13;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic [DIVW-1:0] BaudRate;
    logic            RXD;
    logic            odd_mode;
    logic            fifo_rdreq;
    logic [DW-1:0]   fifo_data;
    logic [1:0]      fifo_err;
    logic            RXD_DATA_VALID_STATUS;
    logic [CW-1:0]   fifo_count;
    logic            overrun;
    logic            rx_busy;

    int n_checks = 0;
    int n_errors = 0;
    int ovr_pulses = 0;
    logic [DW+1:0] exp_q[$];

    typedef struct {
        logic [DW-1:0] data;
        int            baud;
        logic          stop_lvl;
        int            hold;
        logic [1:0]    exp_err;
    } vec_t;
    vec_t vt[6];

    uart_rx_multi #(
        .DATA_W(DW), .STOP_BITS(SB), .DIV_W(DIVW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .BaudRate              (BaudRate),
        .RXD                   (RXD),
`ifdef UART_RX_PARITY_EN
        .parity_odd            (odd_mode),
`endif
        .fifo_rdreq            (fifo_rdreq),
        .fifo_data             (fifo_data),
        .fifo_err              (fifo_err),
        .RXD_DATA_VALID_STATUS (RXD_DATA_VALID_STATUS),
        .fifo_count            (fifo_count),
        .overrun               (overrun),
        .rx_busy               (rx_busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (overrun === 1'b1) ovr_pulses <= ovr_pulses + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model of one received entry, from the frame as put on the line.
    function automatic logic [DW+1:0] model(input logic [DW-1:0] d, input logic pbit,
                                            input logic odd, input logic stop_lvl);
        logic pe;
        pe = PAR && ((($countones(d) + int'(pbit)) % 2) != int'(odd));
        return {pe, !stop_lvl, d};
    endfunction

    // Line level of bit b of a frame (0 = start bit); idle high past the end.
    function automatic logic fbit(input logic [DW-1:0] d, input logic pb, input int b);
        if (b == 0) return 1'b0;
        if (b <= DW) return d[b-1];
        if (PAR && b == DW + 1) return pb;
        return 1'b1;
    endfunction

    task automatic send_frame(input logic [DW-1:0] data, input int baud, input logic pbit,
                              input logic stop_lvl, input int hold, input bit scramble);
        BaudRate = DIVW'(baud);
        RXD = 1'b0;
        for (int c = 0; c < baud; c++) begin
            tick();
            if (scramble && c == 2) BaudRate = DIVW'($urandom_range(8, 60));
        end
        for (int i = 0; i < DW; i++) begin
            RXD = data[i];
            repeat (baud) tick();
        end
        if (PAR) begin
            RXD = pbit;
            repeat (baud) tick();
        end
        for (int s = 0; s < SB; s++) begin
            RXD = stop_lvl;
            repeat (baud) tick();
        end
        if (!stop_lvl) repeat (hold) tick();
        RXD = 1'b1;
    endtask

    task automatic wait_valid(input string name, input int max_cycles);
        int c = 0;
        while (RXD_DATA_VALID_STATUS !== 1'b1 && c < max_cycles) begin
            tick();
            c++;
        end
        if (RXD_DATA_VALID_STATUS !== 1'b1) check({name, "_timeout"}, RXD_DATA_VALID_STATUS, 1);
    endtask

    task automatic pop_check(input string name);
        logic [DW+1:0] e;
        e = exp_q.pop_front();
        check({name, "_valid"}, RXD_DATA_VALID_STATUS, 1);
        check({name, "_data"}, fifo_data, e[DW-1:0]);
        check({name, "_err"}, fifo_err, e[DW+1:DW]);
        $display("pop %s data=%02h err=%b count=%0d", name, fifo_data, fifo_err, fifo_count);
        fifo_rdreq = 1'b1;
        tick();
        fifo_rdreq = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        RXD = 1'b1;
        fifo_rdreq = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        exp_q.delete();
    endtask

    initial begin
        logic [DW-1:0] d;
        logic pb, sl;
        int b, hold, e_edge, nb, ovr_base;

        vt[0] = '{8'hA5, 16, 1'b1, 0,  2'b00};
        vt[1] = '{8'h00, 8,  1'b1, 0,  2'b00};
        vt[2] = '{8'hFF, 9,  1'b1, 0,  2'b00};
        vt[3] = '{8'h5A, 33, 1'b0, 0,  2'b01};
        vt[4] = '{8'h01, 20, 1'b0, 30, 2'b01};
        vt[5] = '{8'h80, 12, 1'b1, 0,  2'b00};

        odd_mode = 1'b0;
        BaudRate = DIVW'(16);
        do_reset();

        // Reset state
        check("rst_valid", RXD_DATA_VALID_STATUS, 0);
        check("rst_count", fifo_count, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", rx_busy, 0);
        check("rst_data", fifo_data, 0);
        check("rst_err", fifo_err, 0);

        // Latency: 0xA5 at BaudRate 16; last stop sample lands 2+8+16*(bits-1) edges after the start.
        d = 8'hA5;
        pb = (^d) ^ odd_mode;
        nb = 1 + DW + int'(PAR) + SB;
        e_edge = 2 + 8 + 16 * (nb - 1);
        BaudRate = DIVW'(16);
        RXD = 1'b0;
        for (int m = 1; m <= 16 * nb + 4; m++) begin
            tick();
            b = m / 16;
            RXD = fbit(d, pb, b);
            if (m == e_edge) check("lat_before", RXD_DATA_VALID_STATUS, 0);
            if (m == e_edge + 1) check("lat_after", RXD_DATA_VALID_STATUS, 1);
        end
        $display("frame lat data=%02h", d);
        check("lat_count", fifo_count, 1);
        exp_q.push_back(model(d, pb, odd_mode, 1'b1));
        pop_check("lat");

        // Glitch: 4 clocks low in IDLE, start sample at HALF rejects it.
        RXD = 1'b0;
        for (int m = 1; m <= 14; m++) begin
            tick();
            if (m == 4) RXD = 1'b1;
            if (m == 9) check("glitch_busy_mid", rx_busy, 1);
            if (m == 11) check("glitch_busy_end", rx_busy, 0);
        end
        repeat (20) tick();
        check("glitch_count", fifo_count, 0);
        $display("frame glitch rejected");

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            pb = (^vt[i].data) ^ odd_mode;
            send_frame(vt[i].data, vt[i].baud, pb, vt[i].stop_lvl, vt[i].hold, 1'b0);
            repeat (4) tick();
            wait_valid("tbl", 100);
            $display("frame tbl%0d data=%02h baud=%0d stop=%0b", i, vt[i].data, vt[i].baud, vt[i].stop_lvl);
            check("tbl_data", fifo_data, vt[i].data);
            check("tbl_err", fifo_err, vt[i].exp_err);
            fifo_rdreq = 1'b1;
            tick();
            fifo_rdreq = 1'b0;
            check("tbl_count_after_pop", fifo_count, 0);
        end

        // Framing error with a long break: stored once, no re-trigger while low.
        d = 8'h3C;
        pb = (^d) ^ odd_mode;
        send_frame(d, 16, pb, 1'b0, 100, 1'b0);
        check("brk_count", fifo_count, 1);
        check("brk_busy", rx_busy, 1);
        exp_q.push_back(model(d, pb, odd_mode, 1'b0));
        pop_check("brk");
        repeat (40) tick();
        check("brk_count_after", fifo_count, 0);
        check("brk_busy_after", rx_busy, 0);

        // Fill: five words, no reads, FIFO holds four.
        ovr_base = ovr_pulses;
        for (int i = 0; i < 5; i++) begin
            d = DW'(8'h11 * (i + 1));
            pb = (^d) ^ odd_mode;
            send_frame(d, 12, pb, 1'b1, 0, 1'b0);
            repeat (3) tick();
            if (exp_q.size() < DEPTH) exp_q.push_back(model(d, pb, odd_mode, 1'b1));
            $display("frame fill%0d data=%02h count=%0d", i, d, fifo_count);
        end
        check("fill_count", fifo_count, DEPTH);
        check("fill_overrun", ovr_pulses - ovr_base, 1);
        check("fill_head", fifo_data, 8'h11);
        while (exp_q.size() > 0) pop_check("fill");
        fifo_rdreq = 1'b1;
        tick();
        fifo_rdreq = 1'b0;
        check("empty_read_count", fifo_count, 0);
        check("empty_read_valid", RXD_DATA_VALID_STATUS, 0);

`ifdef UART_RX_PARITY_EN
        // Even parity with 0x07 expects parity bit 1.
        odd_mode = 1'b0;
        send_frame(8'h07, 16, 1'b0, 1'b1, 0, 1'b0);
        repeat (4) tick();
        wait_valid("par0", 100);
        check("par_bad_err", fifo_err, 2'b10);
        fifo_rdreq = 1'b1; tick(); fifo_rdreq = 1'b0;
        send_frame(8'h07, 16, 1'b1, 1'b1, 0, 1'b0);
        repeat (4) tick();
        wait_valid("par1", 100);
        check("par_good_err", fifo_err, 2'b00);
        fifo_rdreq = 1'b1; tick(); fifo_rdreq = 1'b0;
        $display("frame parity pair done");
`endif

        // Reset in the middle of the data bits of 0x55.
        d = 8'h55;
        BaudRate = DIVW'(16);
        RXD = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < 3; i++) begin
            RXD = d[i];
            repeat (16) tick();
        end
        reset = 1'b1;
        RXD = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("mrst_count", fifo_count, 0);
        check("mrst_busy", rx_busy, 0);
        repeat (20) tick();
        d = 8'h81;
        pb = (^d) ^ odd_mode;
        send_frame(d, 16, pb, 1'b1, 0, 1'b0);
        repeat (4) tick();
        check("mrst_count_after", fifo_count, 1);
        exp_q.push_back(model(d, pb, odd_mode, 1'b1));
        pop_check("mrst");

        // Randomised frames; divisor scrambled after each start edge.
        for (int n = 0; n < 24; n++) begin
            int baud;
            baud = $urandom_range(8, 40);
            d = DW'($urandom);
            odd_mode = PAR ? 1'($urandom % 2) : 1'b0;
            pb = (^d) ^ odd_mode ^ 1'($urandom % 2);
            sl = ($urandom % 5) != 0;
            hold = sl ? 0 : int'($urandom % (2 * baud));
            send_frame(d, baud, pb, sl, hold, 1'b1);
            repeat (3 + $urandom % 4) tick();
            exp_q.push_back(model(d, pb, odd_mode, sl));
            $display("frame rnd%0d data=%02h baud=%0d stop=%0b hold=%0d", n, d, baud, sl, hold);
            check("rnd_count", fifo_count, exp_q.size());
            if (exp_q.size() >= 3 || ($urandom % 2) == 1) begin
                wait_valid("rnd", 50);
                pop_check("rnd");
            end
        end
        while (exp_q.size() > 0) begin
            wait_valid("drain", 50);
            pop_check("drain");
        end
        check("final_count", fifo_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
